lcd_scan_ctrl: RTL and testbench

LCD_SCAN_CTRL -- requirements
Module: lcd_scan_ctrl

---
 rtl/lcd_scan_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_lcd_scan_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_scan_ctrl.sv
// lcd_scan_ctrl: drives an HD44780-style character LCD in 8-bit write-only
// mode. After a power-up wait it runs the init sequence once (0x38, 0x0C,
// 0x06, 0x01). It then refreshes the 2x16 display forever from an external
// formatter. The formatter is addressed by 'index' and answers on 'char_in'
// one cycle later.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   char_in    character for the position on 'index' (registered source)
//   index      requested character position 0..31 (16..31 = line 2)
//   lcd_e      LCD enable strobe
//   lcd_rs     0 = command, 1 = data
//   lcd_rw     always 0
//   lcd_data   LCD data bus
//   init_done  high once the init sequence has finished
//   frame_done one-cycle pulse when index wraps from 31 back to 0
//   state_dbg  current FSM state, for observation only
//
// Every byte write has the same shape:
//   - 1 SETUP cycle with lcd_e=0.
//   - E_CYC cycles with lcd_e=1.
//   - HOLD cycles with lcd_e=0. HOLD is CLR_CYC after the clear command
//     (command 0x01), and CMD_CYC after every other byte.
// lcd_rs and lcd_data are loaded on the edge that enters SETUP. They are not
// touched again until the write ends.
module lcd_scan_ctrl #(
    parameter int unsigned PWRUP_CYC = 750000,
    parameter int unsigned E_CYC     = 25,
    parameter int unsigned CMD_CYC   = 2500,
    parameter int unsigned CLR_CYC   = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_in,
    output logic [4:0] index,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data,
    output logic       init_done,
    output logic       frame_done,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_PWRUP     = 3'd0,
        S_INIT      = 3'd1,
        S_ADDR      = 3'd2,
        S_CHAR_PREP = 3'd3,
        S_CHAR_WR   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        W_SETUP = 2'd0,
        W_E     = 2'd1,
        W_HOLD  = 2'd2
    } wph_t;

    localparam logic [23:0] PWRUP_M1 = 24'(PWRUP_CYC - 1);
    localparam logic [23:0] E_M1     = 24'(E_CYC - 1);
    localparam logic [23:0] CMD_M1   = 24'(CMD_CYC - 1);
    localparam logic [23:0] CLR_M1   = 24'(CLR_CYC - 1);

    state_t      state_q, state_d;
    wph_t        wph_q, wph_d;
    logic [23:0] cnt_q, cnt_d;
    logic [1:0]  step_q, step_d;
    logic [4:0]  index_q, index_d;
    logic        lcd_e_q, lcd_e_d;
    logic        lcd_rs_q, lcd_rs_d;
    logic [7:0]  lcd_data_q, lcd_data_d;
    logic        init_done_q, init_done_d;
    logic        frame_done_q, frame_done_d;

    logic [23:0] hold_m1;
    logic        in_write;
    logic        wr_done;

    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        case (step)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h06;
            default: init_cmd = 8'h01;
        endcase
    endfunction

    // The long hold applies only to the clear command. A data byte 0x01
    // (rs=1) still uses the normal hold.
    assign hold_m1  = (lcd_data_q == 8'h01 && !lcd_rs_q) ? CLR_M1 : CMD_M1;
    assign in_write = (state_q == S_INIT) || (state_q == S_ADDR) || (state_q == S_CHAR_WR);
    assign wr_done  = in_write && (wph_q == W_HOLD) && (cnt_q == hold_m1);

    always_comb begin
        state_d      = state_q;
        wph_d        = wph_q;
        cnt_d        = cnt_q;
        step_d       = step_q;
        index_d      = index_q;
        lcd_e_d      = lcd_e_q;
        lcd_rs_d     = lcd_rs_q;
        lcd_data_d   = lcd_data_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;

        // Shared byte-write sequencer. The state case below decides what
        // comes next when the write finishes.
        if (in_write) begin
            case (wph_q)
                W_SETUP: begin
                    lcd_e_d = 1'b1;
                    wph_d   = W_E;
                    cnt_d   = '0;
                end
                W_E: begin
                    if (cnt_q == E_M1) begin
                        lcd_e_d = 1'b0;
                        wph_d   = W_HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 24'd1;
                    end
                end
                W_HOLD: begin
                    if (cnt_q == hold_m1) begin
                        wph_d = W_SETUP;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 24'd1;
                    end
                end
                default: begin
                    wph_d = W_SETUP;
                    cnt_d = '0;
                end
            endcase
        end

        case (state_q)
            S_PWRUP: begin
                if (cnt_q == PWRUP_M1) begin
                    state_d    = S_INIT;
                    cnt_d      = '0;
                    wph_d      = W_SETUP;
                    step_d     = 2'd0;
                    lcd_rs_d   = 1'b0;
                    lcd_data_d = init_cmd(2'd0);
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            S_INIT: begin
                if (wr_done) begin
                    if (step_q == 2'd3) begin
                        init_done_d = 1'b1;
                        state_d     = S_ADDR;
                        lcd_data_d  = 8'h80;
                    end else begin
                        step_d     = step_q + 2'd1;
                        lcd_data_d = init_cmd(step_q + 2'd1);
                    end
                end
            end
            S_ADDR: begin
                if (wr_done) begin
                    state_d = S_CHAR_PREP;
                end
            end
            S_CHAR_PREP: begin
                // Two cycles give the formatter time to answer for the
                // current index. The answer is captured as the write begins.
                if (cnt_q == 24'd1) begin
                    state_d    = S_CHAR_WR;
                    cnt_d      = '0;
                    wph_d      = W_SETUP;
                    lcd_rs_d   = 1'b1;
                    lcd_data_d = char_in;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            S_CHAR_WR: begin
                if (wr_done) begin
                    index_d = index_q + 5'd1;
                    if (index_q == 5'd31) begin
                        frame_done_d = 1'b1;
                    end
                    if (index_d == 5'd0 || index_d == 5'd16) begin
                        state_d    = S_ADDR;
                        lcd_rs_d   = 1'b0;
                        lcd_data_d = (index_d == 5'd0) ? 8'h80 : 8'hC0;
                    end else begin
                        state_d = S_CHAR_PREP;
                    end
                end
            end
            default: begin
                state_d = S_PWRUP;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_PWRUP;
            wph_q        <= W_SETUP;
            cnt_q        <= '0;
            step_q       <= '0;
            index_q      <= '0;
            lcd_e_q      <= 1'b0;
            lcd_rs_q     <= 1'b0;
            lcd_data_q   <= '0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wph_q        <= wph_d;
            cnt_q        <= cnt_d;
            step_q       <= step_d;
            index_q      <= index_d;
            lcd_e_q      <= lcd_e_d;
            lcd_rs_q     <= lcd_rs_d;
            lcd_data_q   <= lcd_data_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign index      = index_q;
    assign lcd_e      = lcd_e_q;
    assign lcd_rs     = lcd_rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_data   = lcd_data_q;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_lcd_scan_ctrl.sv
// Bench for lcd_scan_ctrl with small timing parameters.
//
// The reference model is a list of the bytes the display should receive:
//   - the init commands;
//   - for each frame, the line-1 address, 16 characters, the line-2 address
//     and 16 more characters.
// Rise times, hold lengths, the init_done time and the frame period come
// from plain arithmetic on the parameters. During later frames char_in is
// driven with random junk while a character is being written. This shows
// that the latched byte does not change.
module tb_lcd_scan_ctrl;
    localparam int PWRUP = 4;
    localparam int ECYC  = 2;
    localparam int CMD   = 3;
    localparam int CLR   = 6;
    localparam int PERIOD = 2 * (1 + ECYC + CMD) + 32 * (3 + ECYC + CMD);
    localparam int T_INIT = PWRUP + 1 + 3 * (ECYC + CMD + 1) + ECYC + CLR;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] char_in;
    logic [4:0] index;
    logic       lcd_e, lcd_rs, lcd_rw, init_done, frame_done;
    logic [7:0] lcd_data;
    logic [2:0] state_dbg;

    lcd_scan_ctrl #(.PWRUP_CYC(PWRUP), .E_CYC(ECYC), .CMD_CYC(CMD), .CLR_CYC(CLR)) dut (
        .clk(clk), .rst(rst), .char_in(char_in), .index(index), .lcd_e(lcd_e),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data), .init_done(init_done),
        .frame_done(frame_done), .state_dbg(state_dbg)
    );

    // clock
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // expected write list: {index, rs, data}
    logic [13:0] exp_q[$];

    task automatic push_init();
        exp_q.push_back({5'd0, 1'b0, 8'h38});
        exp_q.push_back({5'd0, 1'b0, 8'h0C});
        exp_q.push_back({5'd0, 1'b0, 8'h06});
        exp_q.push_back({5'd0, 1'b0, 8'h01});
    endtask

    task automatic push_frame();
        for (int i = 0; i < 32; i++) begin
            if (i == 0)  exp_q.push_back({5'd0, 1'b0, 8'h80});
            if (i == 16) exp_q.push_back({5'd0, 1'b0, 8'hC0});
            exp_q.push_back({5'(i), 1'b1, 8'(8'h40 + i)});
        end
    endtask

    // char_in driver: a registered copy of the formatter's answer. It sends
    // junk while a character write is in progress, once rand_mode is set.
    logic       rand_mode = 1'b0;
    logic [7:0] nxt;
    initial begin
        char_in = 8'h00;
        forever begin
            @(negedge clk);
            if (rand_mode && state_dbg == 3'd4) nxt = 8'($urandom_range(0, 255));
            else nxt = 8'h40 + {3'b000, index};
            @(posedge clk);
            #1 char_in = nxt;
        end
    end

    // monitor state
    logic       mon_en = 1'b0;
    int         cyc, exp_rise, e_width, hold_left, cur_hold, n_fd, last_fd;
    logic       prev_e, prev_rs, prev_fd;
    logic [7:0] prev_data, wr_data;
    logic       wr_rs;
    logic [13:0] ent;

    task automatic init_mon();
        cyc = 0; exp_rise = PWRUP + 1; e_width = 0; hold_left = 0; cur_hold = CMD;
        n_fd = 0; last_fd = 0; prev_e = 1'b0; prev_rs = 1'b0; prev_fd = 1'b0;
        prev_data = 8'h00; wr_data = 8'h00; wr_rs = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cyc++;
                chk("rw", 32'(lcd_rw), 32'd0);
                chk("init_done", 32'(init_done), 32'(cyc >= T_INIT));
                if (lcd_e && !prev_e) begin
                    chk("setup_data", 32'(lcd_data), 32'(prev_data));
                    chk("setup_rs", 32'(lcd_rs), 32'(prev_rs));
                    chk("rise_cyc", 32'(cyc), 32'(exp_rise));
                    chk("exp_avail", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        ent = exp_q.pop_front();
                        chk("data", 32'(lcd_data), 32'(ent[7:0]));
                        chk("rs", 32'(lcd_rs), 32'(ent[8]));
                        if (ent[8]) chk("char_index", 32'(index), 32'(ent[13:9]));
                        cur_hold = (ent[7:0] == 8'h01 && !ent[8]) ? CLR : CMD;
                        exp_rise = cyc + ECYC + cur_hold + 1;
                        if (exp_q.size() != 0 && exp_q[0][8]) exp_rise += 2;
                    end
                    wr_data = lcd_data; wr_rs = lcd_rs; e_width = 1;
                end else if (lcd_e) begin
                    e_width++;
                    chk("e_data", 32'(lcd_data), 32'(wr_data));
                end else if (prev_e) begin
                    chk("e_width", 32'(e_width), 32'(ECYC));
                    chk("hold_data", 32'(lcd_data), 32'(wr_data));
                    chk("hold_rs", 32'(lcd_rs), 32'(wr_rs));
                    hold_left = cur_hold - 1;
                end else if (hold_left > 0) begin
                    chk("hold_data", 32'(lcd_data), 32'(wr_data));
                    chk("hold_rs", 32'(lcd_rs), 32'(wr_rs));
                    hold_left--;
                end
                if (frame_done) begin
                    chk("fd_width", 32'(prev_fd), 32'd0);
                    chk("fd_index", 32'(index), 32'd0);
                    if (n_fd == 0) chk("fd_first", 32'(cyc), 32'(T_INIT + PERIOD));
                    else chk("fd_period", 32'(cyc - last_fd), 32'(PERIOD));
                    last_fd = cyc;
                    n_fd++;
                end
                prev_e = lcd_e; prev_rs = lcd_rs; prev_data = lcd_data; prev_fd = frame_done;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_e"}, 32'(lcd_e), 32'd0);
        chk({tag, "_rs"}, 32'(lcd_rs), 32'd0);
        chk({tag, "_rw"}, 32'(lcd_rw), 32'd0);
        chk({tag, "_data"}, 32'(lcd_data), 32'd0);
        chk({tag, "_index"}, 32'(index), 32'd0);
        chk({tag, "_init_done"}, 32'(init_done), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1;
        init_mon();
        rst = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (n_fd < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("frame_timeout", 32'(n_fd >= n), 32'd1);
    endtask

    initial begin
        logic found;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");

        exp_q.delete();
        push_init();
        for (int f = 0; f < 4; f++) push_frame();
        release_reset();

        wait_frames(1, 2 * PERIOD);
        rand_mode = 1'b1;
        wait_frames(2, 2 * PERIOD);

        // Abort a character write while the strobe is high.
        found = 1'b0;
        for (int k = 0; k < 2 * PERIOD && !found; k++) begin
            @(negedge clk);
            if (lcd_e && lcd_rs && index == 5'd5) found = 1'b1;
        end
        chk("found_idx5", 32'(found), 32'd1);
        mon_en = 1'b0;
        #2 rst = 1'b0;
        #1 check_reset_outputs("abort");
        repeat ($urandom_range(2, 6)) @(negedge clk);
        check_reset_outputs("held");

        exp_q.delete();
        push_init();
        for (int f = 0; f < 2; f++) push_frame();
        release_reset();
        wait_frames(1, 2 * PERIOD);
        repeat (40) @(negedge clk);
        mon_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
